// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the datapath channel muxes
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int MUX_W = 16;
  localparam int MUX_N = 8;

  // Channel index successor with an explicit wrap at n-1 (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority arbiter starting at ptr
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = MUX_N,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;
  logic          hi_ok;
  logic          lo_ok;

  // Scanning downward leaves the lowest requester at/after ptr in hi_idx and the
  // lowest requester overall in lo_idx, which is the wrapped-around winner.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_idx = SW'(k);
        lo_ok  = 1'b1;
        if (k >= int'(ptr)) begin
          hi_idx = SW'(k);
          hi_ok  = 1'b1;
        end
      end
    end
    grant       = hi_ok ? hi_idx : lo_idx;
    grant_valid = en & lo_ok;
  end

endmodule

// File: rtl/mux_rr_n.sv
// rtl/mux_rr_n.sv - N-channel arbitrated mux with a one-entry flow-controlled output register
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int W = MUX_W,
  parameter int N = MUX_N,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [N-1:0] ONE = {{(N - 1){1'b0}}, 1'b1};

  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_grant;
  logic          rr_valid;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic          fixed_hit;
  logic          load_en;
  logic          xfer_in;
  logic [W-1:0]  grant_word;

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .en          (mode == MODE_RR),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // A select value past the last channel shifts the one-hot mask out entirely.
  assign fixed_hit = |(in_valid & (ONE << sel));

  always_comb begin
    grant       = rr_grant;
    grant_valid = rr_valid;
    if (mode == MODE_FIXED) begin
      grant       = sel;
      grant_valid = fixed_hit;
    end
  end

  assign load_en    = !out_valid | out_ready;
  assign xfer_in    = load_en & grant_valid & !rst;
  assign in_ready   = xfer_in ? (ONE << grant) : '0;
  assign grant_word = in_data[int'(grant) * W +: W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      if (xfer_in) begin
        out_data  <= grant_word;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          ptr <= SW'(wrap_inc(int'(grant), N));
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// tb/tb_mux_rr_n.sv - scoreboard bench for mux_rr_n at N=8, N=5 and N=10
module tb_mux_rr_n;

  typedef struct {
    int chan;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] d8;
  logic [7:0]   v8, r8;
  logic         m8, ov8, ordy8;
  logic [2:0]   s8, oc8;
  logic [15:0]  od8;

  logic [39:0]  d5;
  logic [4:0]   v5, r5;
  logic         ov5, ordy5;
  logic [2:0]   s5, oc5;
  logic [7:0]   od5;

  logic [159:0] d10;
  logic [9:0]   v10, r10;
  logic         m10, ov10, ordy10;
  logic [3:0]   s10, oc10;
  logic [15:0]  od10;

  mux_rr_n #(.W(16), .N(8)) u8 (
    .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(r8), .mode(m8), .sel(s8),
    .out_data(od8), .out_chan(oc8), .out_valid(ov8), .out_ready(ordy8));

  mux_rr_n #(.W(8), .N(5)) u5 (
    .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5), .in_ready(r5), .mode(1'b0), .sel(s5),
    .out_data(od5), .out_chan(oc5), .out_valid(ov5), .out_ready(ordy5));

  mux_rr_n #(.W(16), .N(10)) u10 (
    .clk(clk), .rst(rst), .in_data(d10), .in_valid(v10), .in_ready(r10), .mode(m10), .sel(s10),
    .out_data(od10), .out_chan(oc10), .out_valid(ov10), .out_ready(ordy10));

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q8[$], q5[$], q10[$];
  exp_t e8, e5, e10;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q8.delete();
    q5.delete();
    q10.delete();
  endtask

  always @(negedge clk) begin
    if (ov8 && ordy8) begin
      chk("u8 word with empty scoreboard", int'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("u8 out_chan", int'(oc8), e8.chan);
        chk("u8 out_data", int'(od8), e8.data);
      end
    end
  end

  always @(negedge clk) begin
    if (ov5 && ordy5) begin
      chk("u5 word with empty scoreboard", int'(q5.size() != 0), 1);
      if (q5.size() != 0) begin
        e5 = q5.pop_front();
        chk("u5 out_chan", int'(oc5), e5.chan);
        chk("u5 out_data", int'(od5), e5.data);
      end
    end
  end

  always @(negedge clk) begin
    if (ov10 && ordy10) begin
      chk("u10 word with empty scoreboard", int'(q10.size() != 0), 1);
      if (q10.size() != 0) begin
        e10 = q10.pop_front();
        chk("u10 out_chan", int'(oc10), e10.chan);
        chk("u10 out_data", int'(od10), e10.data);
      end
    end
  end

  int rr_data[8] = '{6234, 725, 7524, 5734, 8354, 28457, 2458, 2547};
  int sparse_ch[3] = '{1, 6, 1};

  initial begin
    rst = 1'b1;
    d8 = '0; v8 = '0; m8 = 1'b0; s8 = '0; ordy8 = 1'b0;
    d5 = '0; v5 = '0; s5 = '0; ordy5 = 1'b0;
    d10 = '0; v10 = '0; m10 = 1'b0; s10 = '0; ordy10 = 1'b0;
    step();
    step();
    chk("reset u8 out_valid", int'(ov8), 0);
    chk("reset u8 out_data", int'(od8), 0);
    chk("reset u8 out_chan", int'(oc8), 0);
    chk("reset u8 in_ready", int'(r8), 0);
    chk("reset u5 out_valid", int'(ov5), 0);
    chk("reset u10 out_valid", int'(ov10), 0);
    rst = 1'b0;

    // round-robin fairness, all channels requesting
    for (int k = 0; k < 8; k++) d8[k*16 +: 16] = 16'(rr_data[k]);
    v8 = 8'hFF;
    ordy8 = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      chk("rr in_ready", int'(r8), 1 << (i % 8));
      q8.push_back('{i % 8, rr_data[i % 8]});
      step();
      chk("rr out_valid each cycle", int'(ov8), 1);
    end
    v8 = '0;
    step();
    chk("rr drained", int'(ov8), 0);

    // sparse requests with pointer wrap: ch6 alone leaves ptr=7
    do_reset();
    d8[6*16 +: 16] = 16'd606;
    d8[1*16 +: 16] = 16'd101;
    v8 = 8'h40;
    #1;
    chk("sparse prime in_ready", int'(r8), 64);
    q8.push_back('{6, 606});
    step();
    v8 = 8'h42;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("sparse in_ready", int'(r8), 1 << sparse_ch[i]);
      q8.push_back('{sparse_ch[i], (sparse_ch[i] == 1) ? 101 : 606});
      step();
    end
    v8 = '0;
    step();
    chk("sparse drained", int'(ov8), 0);

    // backpressure on channel 3
    do_reset();
    ordy8 = 1'b0;
    d8[3*16 +: 16] = 16'd9353;
    v8 = 8'h08;
    #1;
    chk("bp first in_ready", int'(r8), 8);
    q8.push_back('{3, 9353});
    step();
    d8[3*16 +: 16] = 16'd1111;
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready held", int'(r8), 0);
      chk("bp out_data stable", int'(od8), 9353);
      chk("bp out_chan stable", int'(oc8), 3);
      chk("bp out_valid", int'(ov8), 1);
      step();
    end
    ordy8 = 1'b1;
    q8.push_back('{3, 1111});
    #1;
    chk("bp release in_ready", int'(r8), 8);
    step();
    v8 = '0;
    chk("bp reload out_data", int'(od8), 1111);
    step();
    chk("bp drained", int'(ov8), 0);

    // fixed mode; ch2 first leaves ptr=3, which fixed mode must not disturb
    do_reset();
    for (int k = 0; k < 8; k++) d8[k*16 +: 16] = 16'(1000 + k);
    d8[5*16 +: 16] = 16'd5482;
    v8 = 8'h04;
    q8.push_back('{2, 1002});
    step();
    v8 = '0;
    step();
    m8 = 1'b1;
    s8 = 3'd5;
    v8 = 8'hFF;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("fixed in_ready", int'(r8), 32);
      q8.push_back('{5, 5482});
      step();
    end
    v8 = 8'hDF;
    #1;
    chk("fixed sel invalid no grant", int'(r8), 0);
    step();
    chk("fixed no load", int'(ov8), 0);
    m8 = 1'b0;
    v8 = 8'hFF;
    #1;
    chk("ptr held across fixed mode", int'(r8), 8);
    q8.push_back('{3, 1003});
    step();
    v8 = '0;
    step();
    chk("fixed drained", int'(ov8), 0);

    // fixed mode at N=10: sel=9 legal, sel>=10 selects nothing
    for (int k = 0; k < 10; k++) d10[k*16 +: 16] = 16'(1000 + k);
    d10[9*16 +: 16] = 16'd9999;
    m10 = 1'b1;
    s10 = 4'd9;
    v10 = 10'h3FF;
    ordy10 = 1'b1;
    #1;
    chk("n10 sel=9 in_ready", int'(r10), 512);
    q10.push_back('{9, 9999});
    step();
    s10 = 4'd12;
    #1;
    chk("n10 sel=12 no grant", int'(r10), 0);
    s10 = 4'd10;
    #1;
    chk("n10 sel=10 no grant", int'(r10), 0);
    step();
    v10 = '0;
    chk("n10 no load", int'(ov10), 0);

    // non-power-of-two round robin at N=5
    for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'(10 * (k + 1));
    v5 = 5'h1F;
    ordy5 = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("n5 in_ready", int'(r5), 1 << (i % 5));
      q5.push_back('{i % 5, 10 * (i % 5 + 1)});
      step();
    end
    v5 = '0;
    step();
    chk("n5 drained", int'(ov5), 0);

    // asynchronous reset while FULL; ptr=5 beforehand so a ptr leak would pick ch6
    ordy8 = 1'b0;
    d8[4*16 +: 16] = 16'd4444;
    d8[6*16 +: 16] = 16'd6666;
    v8 = 8'h10;
    q8.push_back('{4, 4444});
    step();
    chk("pre-reset full", int'(ov8), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset out_valid", int'(ov8), 0);
    chk("async reset out_data", int'(od8), 0);
    chk("async reset out_chan", int'(oc8), 0);
    chk("async reset in_ready", int'(r8), 0);
    q8.delete();
    step();
    rst = 1'b0;
    v8 = 8'h50;
    ordy8 = 1'b1;
    #1;
    chk("first grant after reset", int'(r8), 16);
    q8.push_back('{4, 4444});
    step();
    v8 = '0;
    step();
    chk("post-reset drained", int'(ov8), 0);

    step();
    chk("u8 scoreboard empty", q8.size(), 0);
    chk("u5 scoreboard empty", q5.size(), 0);
    chk("u10 scoreboard empty", q10.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel, W-bit multiplexer with arbitration and a registered, flow-controlled output. It replaces the fixed 8-input 16-bit combinational selector in the datapath wherever several producers share one consumer. Each channel presents a word with valid/ready; the block either round-robins among requesting channels or follows an external select, then holds the chosen word in a one-entry output register until the consumer accepts it.

## Interface
- W, default 16: data width per channel, ≥1.
- N, default 8: channel count, ≥2; need not be a power of two.
- SW, default $clog2(N): select/channel-index width (derived, not overridden).

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- in_valid  in  N  channel k has a word.
- in_ready  out  N  one-hot or zero; channel k word accepted this cycle.
- mode  in  1  0 = round-robin, 1 = fixed select.
- sel  in  SW  channel used in fixed mode; values ≥N select nothing.
- out_data  out  W  registered word.
- out_chan  out  SW  source channel of out_data.
- out_valid  out  1  output register full.
- out_ready  in  1  consumer accepts out_data when out_valid is high.

## Operation
- Output register has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid | out_ready.
- Grant g is computed combinationally each cycle:
  - Round-robin: first k with in_valid[k], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Fixed: g = sel when sel<N and in_valid[sel]; otherwise no grant.
- in_ready[g] = load_en & grant_valid. All other in_ready bits are 0.
- Transfer-in occurs when in_ready[g] is 1. On the next edge: out_data ← channel g word, out_chan ← g, out_valid ← 1.
- Transfer-out occurs when out_valid & out_ready.
  - If there is no simultaneous transfer-in, out_valid ← 0.
  - If there is a simultaneous transfer-in, the register reloads and stays FULL.
- The register is not modified while FULL and out_ready=0. out_data and out_chan are stable under backpressure.
- Round-robin pointer ptr:
  - Updates only on a transfer-in while mode=0: ptr ← g+1, or 0 when g=N-1. Wrap is explicit, not modulo 2^SW.
  - In fixed mode, ptr is held unchanged.
- mode and sel are sampled combinationally. A change affects the grant in the same cycle but never alters a word already in the register.
- Requests with no grant are not dropped. The producer holds in_valid and in_data until its in_ready is seen.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready=0 while rst is high.
- Latency is 1 cycle: a word accepted at edge t is visible on out_data after edge t.
- Throughput is one word per cycle with out_ready held high.
- Under backpressure, in_ready stays all-zero while FULL and out_ready=0.
- Reset asserted mid-operation discards the held word immediately (asynchronous). The first grant after reset release uses ptr=0.
- in_valid changes between cycles are legal. The grant is re-evaluated every cycle; there is no grant lock.
- With no valid requests, out_valid deasserts after the pending word drains.

## Structure
- Shared package mux_pkg:
  - MODE_RR = 1'b0, MODE_FIXED = 1'b1.
  - Default W and N constants shared with other datapath blocks.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N-1:0], ptr, en.
  - Outputs: grant index, grant_valid.
  - Purely combinational priority rotate. Pointer register and output register live in mux_rr_n.
- Fixed-mode selection and final grant mux are in the top level.
- Bit-slicing of in_data uses an indexed part-select. No per-bit instance arrays.

## Test plan
- Reset and idle:
  - Stimulus: rst high mid-run with the register FULL.
  - Required: out_valid, out_data and out_chan read 0 before the next edge; ptr returns to 0; the first grant after release goes to the lowest requesting channel.
- Round-robin fairness:
  - Stimulus: N=8, W=16, all in_valid=1, data 6234, 725, 7524, 5734, 8354, 28457, 2458, 2547, out_ready=1.
  - Required: out_chan sequence 0,1,…,7,0; out_data matches each channel; one word per cycle.
- Sparse requests and wrap:
  - Stimulus: only channels 6 and 1 valid, ptr=7.
  - Required: grant order 1, 6, 1; ptr wraps from 7 to 0 correctly.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with channel 3 valid (9353).
  - Required: out_data=9353 stable; in_ready all-zero; on release exactly one transfer-out, with an in-flight transfer-in the same cycle.
- Fixed mode:
  - Stimulus: mode=1, sel=5 (5482).
  - Required: only channel 5 is served; with sel=5 and in_valid[5]=0 nothing is granted; sel=9 at N=10 is legal; sel ≥ N yields no grant; ptr unchanged when returning to mode=0.
- Non-power-of-two:
  - Stimulus: N=5, W=8, all channels valid.
  - Required: grant sequence 0,1,2,3,4,0; no grant to phantom indices 5–7.
